// File: rtl/ay38500_pkg.sv
// Shared types and helpers for the paddle timing decoder: FSM state encoding,
// default position constants and the publish-value arithmetic.
package ay38500_pkg;

    typedef enum logic [1:0] {
        PAD_IDLE,
        PAD_DISCHARGE,
        PAD_MEASURE,
        PAD_DONE
    } pad_state_t;

    localparam logic [7:0] PAD_CENTER_POS  = 8'd128;
    localparam logic [7:0] PAD_TIMEOUT_POS = 8'd255;

    // Line count minus the calibration offset, floored at 0 and capped at 255.
    function automatic logic [7:0] padRaw(input logic [8:0] count, input logic [8:0] offset);
        logic [8:0] diff;
        diff = (count > offset) ? (count - offset) : 9'd0;
        return (diff > 9'd255) ? 8'd255 : diff[7:0];
    endfunction

    // 3:1 IIR with rounding; the worst case 3*255+255+2 still fits in 10 bits.
    function automatic logic [7:0] padSmooth(input logic [7:0] prev, input logic [7:0] raw);
        logic [9:0] acc;
        acc = 10'(prev) * 10'd3 + 10'(raw) + 10'd2;
        return acc[9:2];
    endfunction

endpackage

// File: rtl/pad_sync_filter.sv
// Two-flop synchronizer for the asynchronous paddle comparator followed by a
// run-length glitch filter: q rises after FILTER_CLKS consecutive high samples.
module pad_sync_filter #(
    parameter int FILTER_CLKS = 4
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic pad_in,
    output logic q
);

    localparam int            CW      = $clog2(FILTER_CLKS + 1);
    localparam logic [CW-1:0] RUN_MAX = CW'(FILTER_CLKS);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] run_q;

    // A single low sample after synchronization throws away the whole run.
    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            run_q   <= '0;
        end else begin
            sync1_q <= pad_in;
            sync2_q <= sync1_q;
            if (!sync2_q) begin
                run_q <= '0;
            end else if (run_q != RUN_MAX) begin
                run_q <= run_q + CW'(1);
            end
        end
    end

    assign q = (run_q == RUN_MAX);

endmodule

// File: rtl/paddle_timing_decoder.sv
// Measures the delay, in HSYNC lines after the discharge window, until the
// paddle RC crosses threshold and turns it into an 8-bit position per frame.
module paddle_timing_decoder
    import ay38500_pkg::*;
#(
    parameter int DISCHARGE_LINES = 8,
    parameter int LINE_OFFSET     = 16,
    parameter int MAX_LINES       = 300,
    parameter int FILTER_CLKS     = 4,
    parameter int SMOOTH          = 1
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       hs,
    input  logic       vs,
    input  logic       pad_in,
    output logic       discharge,
    output logic [7:0] position,
    output logic       pos_valid,
    output logic       timeout
);

    localparam logic [8:0] DISCH_END = 9'(DISCHARGE_LINES);
    localparam logic [8:0] OFFSET9   = 9'(LINE_OFFSET);
    localparam logic [8:0] MAX9      = 9'(MAX_LINES);

    pad_state_t state_q;
    logic [8:0] lineCnt_q;
    logic [7:0] position_q;
    logic       posValid_q;
    logic       timeout_q;
    logic       discharge_q;
    logic       hs_q;
    logic       vs_q;

    logic       padQual;
    logic       hsRise;
    logic       vsRise;
    logic [8:0] lineCntInc;
    logic [7:0] rawPos;
    logic [7:0] capturePos_d;

    pad_sync_filter #(
        .FILTER_CLKS(FILTER_CLKS)
    ) u_filter (
        .clk_sys(clk_sys),
        .reset  (reset),
        .pad_in (pad_in),
        .q      (padQual)
    );

    assign hsRise       = hs & ~hs_q;
    assign vsRise       = vs & ~vs_q;
    assign lineCntInc   = (lineCnt_q == 9'd511) ? lineCnt_q : (lineCnt_q + 9'd1);
    assign rawPos       = padRaw(lineCnt_q, OFFSET9);
    assign capturePos_d = (SMOOTH != 0) ? padSmooth(position_q, rawPos) : rawPos;

    // vs is tested before everything else, so a coincident hs edge is never counted.
    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            state_q     <= PAD_IDLE;
            lineCnt_q   <= '0;
            position_q  <= PAD_CENTER_POS;
            posValid_q  <= 1'b0;
            timeout_q   <= 1'b0;
            discharge_q <= 1'b0;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
        end else begin
            hs_q       <= hs;
            vs_q       <= vs;
            posValid_q <= 1'b0;
            unique case (state_q)
                PAD_IDLE: begin
                    if (vsRise) begin
                        state_q     <= PAD_DISCHARGE;
                        lineCnt_q   <= '0;
                        discharge_q <= 1'b1;
                    end
                end
                PAD_DISCHARGE: begin
                    if (vsRise) begin
                        lineCnt_q <= '0;
                    end else if (hsRise) begin
                        if (lineCntInc >= DISCH_END) begin
                            state_q     <= PAD_MEASURE;
                            lineCnt_q   <= '0;
                            discharge_q <= 1'b0;
                        end else begin
                            lineCnt_q <= lineCntInc;
                        end
                    end
                end
                PAD_MEASURE: begin
                    // Capture takes priority over hs so a coincident edge sees the old count.
                    if (vsRise) begin
                        position_q  <= PAD_TIMEOUT_POS;
                        timeout_q   <= 1'b1;
                        posValid_q  <= 1'b1;
                        state_q     <= PAD_DISCHARGE;
                        lineCnt_q   <= '0;
                        discharge_q <= 1'b1;
                    end else if (padQual) begin
                        position_q <= capturePos_d;
                        timeout_q  <= 1'b0;
                        posValid_q <= 1'b1;
                        state_q    <= PAD_DONE;
                    end else if (lineCnt_q >= MAX9) begin
                        position_q <= PAD_TIMEOUT_POS;
                        timeout_q  <= 1'b1;
                        posValid_q <= 1'b1;
                        state_q    <= PAD_DONE;
                    end else if (hsRise) begin
                        lineCnt_q <= lineCntInc;
                    end
                end
                PAD_DONE: begin
                    if (vsRise) begin
                        state_q     <= PAD_DISCHARGE;
                        lineCnt_q   <= '0;
                        discharge_q <= 1'b1;
                    end
                end
                default: state_q <= PAD_IDLE;
            endcase
        end
    end

    assign discharge = discharge_q;
    assign position  = position_q;
    assign pos_valid = posValid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_paddle_timing_decoder.sv
// Drives synthetic video frames into a raw and a smoothed decoder instance and
// compares every published position against a line-count model of the paddle.
module tb_paddle_timing_decoder;

    localparam int DISCH    = 8;
    localparam int OFFSET   = 16;
    localparam int MAXL     = 300;
    localparam int FILT     = 4;
    localparam int LINE_CYC = 12;

    logic       clk = 1'b0;
    logic       resetN;
    logic       hs;
    logic       vs;
    logic       padIn;
    logic       discharge0, discharge1;
    logic [7:0] position0, position1;
    logic       posValid0, posValid1;
    logic       timeout0, timeout1;

    int vectors     = 0;
    int miscompares = 0;
    int pub0        = 0;
    int pub1        = 0;
    logic [7:0] lastPos0, lastPos1;
    logic       lastTo0, lastTo1;

    int mPos0, mPos1, mTo;

    always #5 clk = ~clk;

    paddle_timing_decoder #(
        .DISCHARGE_LINES(DISCH), .LINE_OFFSET(OFFSET), .MAX_LINES(MAXL),
        .FILTER_CLKS(FILT), .SMOOTH(0)
    ) dutRaw (
        .clk_sys(clk), .reset(resetN), .hs(hs), .vs(vs), .pad_in(padIn),
        .discharge(discharge0), .position(position0), .pos_valid(posValid0), .timeout(timeout0)
    );

    paddle_timing_decoder #(
        .DISCHARGE_LINES(DISCH), .LINE_OFFSET(OFFSET), .MAX_LINES(MAXL),
        .FILTER_CLKS(FILT), .SMOOTH(1)
    ) dutSmooth (
        .clk_sys(clk), .reset(resetN), .hs(hs), .vs(vs), .pad_in(padIn),
        .discharge(discharge1), .position(position1), .pos_valid(posValid1), .timeout(timeout1)
    );

    // Publish monitor, sampled on the falling edge away from the active edge.
    always @(negedge clk) begin
        if (posValid0 === 1'b1) begin
            pub0     = pub0 + 1;
            lastPos0 = position0;
            lastTo0  = timeout0;
        end
        if (posValid1 === 1'b1) begin
            pub1     = pub1 + 1;
            lastPos1 = position1;
            lastTo1  = timeout1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic hsV, input logic vsV, input logic padV);
        hs    = hsV;
        vs    = vsV;
        padIn = padV;
        @(posedge clk);
        #1;
    endtask

    // Line 0 of a frame: vs and hs rise together, comparator held low.
    task automatic vsLine();
        for (int cyc = 0; cyc < LINE_CYC; cyc++)
            applyStimulus(cyc < 2, cyc < 2, 1'b0);
    endtask

    // Lines 1..frameLines-1; pad rises at padCyc of the line after which the
    // measurement count equals padLine, optionally dropping after glitchLen cycles.
    task automatic runFrame(input int frameLines, input int padLine, input int padCyc, input int glitchLen);
        logic padV;
        int   onCnt;
        padV  = 1'b0;
        onCnt = 0;
        for (int line = 1; line < frameLines; line++) begin
            for (int cyc = 0; cyc < LINE_CYC; cyc++) begin
                if (padLine >= 0 && line == DISCH + padLine && cyc == padCyc) begin
                    padV  = 1'b1;
                    onCnt = 0;
                end else if (padV && glitchLen > 0) begin
                    onCnt++;
                    if (onCnt >= glitchLen) padV = 1'b0;
                end
                applyStimulus(cyc < 2, 1'b0, padV);
                if (line == 4 && cyc == 5) begin
                    checkOutput("discharge_held_raw", discharge0, 1);
                    checkOutput("discharge_held_smooth", discharge1, 1);
                end
                if (line == DISCH + 1 && cyc == 5) begin
                    checkOutput("discharge_released_raw", discharge0, 0);
                    checkOutput("discharge_released_smooth", discharge1, 0);
                end
            end
        end
    endtask

    // Frame outcome from the measurement rules: a qualified crossing before
    // the line limit gives a clamped position, anything else reads as timeout.
    function automatic void modelFrame(input int frameLines, input int padLine, input int glitchLen);
        bit qualifies;
        int raw;
        qualifies = (padLine >= 0) && (glitchLen == 0 || glitchLen >= FILT)
                    && (padLine < MAXL) && (DISCH + padLine < frameLines);
        if (qualifies) begin
            raw = padLine - OFFSET;
            if (raw < 0)   raw = 0;
            if (raw > 255) raw = 255;
            mPos0 = raw;
            mPos1 = (3 * mPos1 + raw + 2) / 4;
            mTo   = 0;
        end else begin
            mPos0 = 255;
            mPos1 = 255;
            mTo   = 1;
        end
    endfunction

    task automatic doFrame(input int frameLines, input int padLine, input int padCyc, input int glitchLen);
        int base0, base1;
        base0 = pub0;
        base1 = pub1;
        runFrame(frameLines, padLine, padCyc, glitchLen);
        vsLine();
        modelFrame(frameLines, padLine, glitchLen);
        checkOutput("publish_count_raw", pub0 - base0, 1);
        checkOutput("publish_count_smooth", pub1 - base1, 1);
        checkOutput("position_raw", lastPos0, mPos0);
        checkOutput("position_smooth", lastPos1, mPos1);
        checkOutput("timeout_at_publish_raw", lastTo0, mTo);
        checkOutput("timeout_level_smooth", timeout1, mTo);
    endtask

    initial begin
        int base0, base1;
        int padLine, padCyc, glitchLen;

        resetN = 1'b0;
        hs     = 1'b0;
        vs     = 1'b0;
        padIn  = 1'b0;
        mPos0  = 128;
        mPos1  = 128;
        mTo    = 0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_position_raw", position0, 128);
        checkOutput("reset_position_smooth", position1, 128);
        checkOutput("reset_pos_valid", posValid0, 0);
        checkOutput("reset_timeout", timeout1, 0);
        checkOutput("reset_discharge", discharge0, 0);
        resetN = 1'b1;

        vsLine();

        // Steady raw 200: smoothed sequence 146, 160, 170.
        doFrame(262, 216, 1, 0);
        doFrame(262, 216, 1, 0);
        doFrame(262, 216, 1, 0);
        doFrame(262, 100, 1, 0);
        doFrame(262, -1, 0, 0);
        doFrame(262, 10, 1, 0);
        doFrame(262, 50, 1, 3);
        doFrame(262, 50, 6, 0);
        doFrame(262, 70, 1, 4);
        doFrame(320, -1, 0, 0);

        for (int f = 0; f < 6; f++) begin
            padLine   = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 252));
            padCyc    = int'($urandom_range(0, 6));
            glitchLen = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
            $display("[TB] random frame %0d: padLine=%0d padCyc=%0d glitchLen=%0d",
                     f, padLine, padCyc, glitchLen);
            doFrame(262, padLine, padCyc, glitchLen);
        end

        base0 = pub0;
        base1 = pub1;
        runFrame(20, -1, 0, 0);
        resetN = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("midreset_position_raw", position0, 128);
        checkOutput("midreset_position_smooth", position1, 128);
        checkOutput("midreset_timeout", timeout0, 0);
        checkOutput("midreset_discharge", discharge1, 0);
        checkOutput("midreset_no_publish", (pub0 - base0) + (pub1 - base1), 0);
        resetN = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/paddle_timing_decoder.md
# paddle_timing_decoder

Converts a real potentiometer/RC paddle signal, sampled on a user-port pin, into an 8-bit paddle position once per video frame. It is the reading end of the paddle timing interface: the chip-side emulation turns a position into a line-delayed pulse after VSYNC; this block measures that delay in HSYNC lines and recovers the position. It sits between `USER_IN` and the paddle-position registers in `emu`, with the same frame timing (`hs`/`vs`, active-high) used by the paddle emulation.

## Interface
Parameters:
- `DISCHARGE_LINES`, 8: lines after VSYNC during which the capacitor is held discharged.
- `LINE_OFFSET`, 16: measured lines subtracted before clamping; calibrates pot minimum.
- `MAX_LINES`, 300: line count at which measurement times out.
- `FILTER_CLKS`, 4: consecutive synchronized-high `clk_sys` samples needed to accept `pad_in`.
- `SMOOTH`, 1: 0 = raw position, 1 = 3:1 IIR smoothing.

Ports:
- `clk_sys` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `hs` in 1: horizontal sync, active-high, `clk_sys` domain.
- `vs` in 1: vertical sync, active-high, `clk_sys` domain.
- `pad_in` in 1: raw asynchronous paddle comparator input, high = threshold reached.
- `discharge` out 1: high = drive open-drain pin low to discharge the RC.
- `position` out 8: latest paddle position, 0 = top.
- `pos_valid` out 1: one-cycle strobe when `position` updates.
- `timeout` out 1: last frame's measurement timed out (sticky until next publish).

## Operation
- `pad_in` passes through a 2-flop synchronizer, then the glitch filter: qualified high after `FILTER_CLKS` consecutive high samples; any low sample clears the filter.
- `hs`/`vs` rising edges are detected against one-cycle-delayed copies.
- States: IDLE, DISCHARGE, MEASURE, DONE.
  - IDLE: after reset; on `vs` rise go to DISCHARGE, clear line counter.
  - DISCHARGE: `discharge`=1; count `hs` rises; at `DISCHARGE_LINES` go to MEASURE, clear counter, `discharge`=0.
  - MEASURE: count `hs` rises (9-bit, saturating at 511). On qualified high, capture the counter and publish. When counter reaches `MAX_LINES`, publish 255 with `timeout`=1. Either leads to DONE.
  - DONE: wait for `vs` rise, then go to DISCHARGE.
- A `vs` rise in MEASURE publishes a timeout (255, `timeout`=1) and re-enters DISCHARGE in the same cycle. A `vs` rise in DISCHARGE restarts DISCHARGE.
- Publish value: raw = counter − `LINE_OFFSET`, clamped to 0; then clamped to 255. With SMOOTH=1, `position` ← (3·position + raw + 2) >> 2 using a 10-bit intermediate. Timeout publishes 255 directly and bypasses smoothing.
- A non-timeout publish clears `timeout`.

## Timing
- Reset values: `position`=128, `pos_valid`=0, `timeout`=0, `discharge`=0, state IDLE, filter and counters 0.
- Edge detection adds 1 cycle. State changes on the cycle after the edge appears on the input.
- `pad_in` to qualified high: 2 + `FILTER_CLKS` cycles. `position`/`pos_valid` are registered 1 cycle later.
- `pos_valid` is high exactly one cycle per publish and at most once per frame.
- Simultaneous `hs` rise and qualified high: capture the pre-increment count.
- Simultaneous `vs` and `hs` rises: `vs` wins and that `hs` is not counted.
- `reset` asserted mid-measurement: everything returns to reset values immediately, with no publish.

## Structure
- Package `ay38500_pkg`: state enum `pad_state_t`, default constants (128 centre position, 255 timeout value).
- One sub-module, `pad_sync_filter`: 2-flop synchronizer plus `FILTER_CLKS` run-length filter with output `q`.
- The top of this block holds the edge detectors, FSM, counter, clamp and IIR.

## Test plan
- SMOOTH=0, pulse going high 100 lines after discharge ends, held high → `position`=84, one `pos_valid`, `timeout`=0.
- `pad_in` never high, frame of 262 lines, `MAX_LINES`=300 → on next `vs` rise `position`=255, `timeout`=1; `discharge` high for the following 8 lines.
- High at 10 lines (< `LINE_OFFSET`) → `position`=0; 3-cycle high glitch with `FILTER_CLKS`=4 → ignored.
- SMOOTH=1 from reset (128), steady raw 200 each frame → 146, 160, 170, … converging to 200.
- Qualified high coincident with an `hs` edge at count 50 → captures 50 (raw 34); `reset` asserted during MEASURE → outputs at reset values, no `pos_valid`.
